// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator and pixel output stage for the layer chain.
//
// Generates the hdata/vdata beam coordinates that feed every layer, then
// delays the raw sync/active timing by PIPE_DELAY pixel ticks.
// The composited pixel arriving from the end of the chain therefore lines up
// with the final delay stage.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   en                  pixel-clock enable; all state advances only when en=1
//   hdata, vdata        current beam position (to the layer chain)
//   pixel               composited pixel {opaque, ..., colour[CWIDTH-1:0]}
//   hsync, vsync        active-low syncs, delayed by PIPE_DELAY en-ticks
//   de, rgb             display enable and colour, aligned with the syncs
//   line_start          one-clk pulse after an en-edge that wrapped hdata
//   frame_start         one-clk pulse after an en-edge that wrapped (hdata,vdata)
//
// Optional feature macro: SCANOUT_BACKDROP_EN
//   When defined, a non-opaque pixel inside the active area renders a 16x16
//   checkerboard (12'h444 / 12'h888) from the delayed beam coordinates.

module vga_scanout #(
  parameter int unsigned HWIDTH     = 12,
  parameter int unsigned VWIDTH     = 12,
  parameter int unsigned DATA_WIDTH = 13,
  parameter int unsigned CWIDTH     = 12,
  parameter int unsigned HSIZE      = 640,
  parameter int unsigned HFP        = 16,
  parameter int unsigned HSYNC      = 96,
  parameter int unsigned HBP        = 48,
  parameter int unsigned VSIZE      = 480,
  parameter int unsigned VFP        = 10,
  parameter int unsigned VSYNC      = 2,
  parameter int unsigned VBP        = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [HWIDTH-1:0]     hdata,
  output logic [VWIDTH-1:0]     vdata,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [CWIDTH-1:0]     rgb,
  output logic                  line_start,
  output logic                  frame_start
);

  localparam int unsigned HTOTAL = HSIZE + HFP + HSYNC + HBP;
  localparam int unsigned VTOTAL = VSIZE + VFP + VSYNC + VBP;
  localparam int unsigned HS_BEG = HSIZE + HFP;
  localparam int unsigned HS_END = HSIZE + HFP + HSYNC;
  localparam int unsigned VS_BEG = VSIZE + VFP;
  localparam int unsigned VS_END = VSIZE + VFP + VSYNC;

  // One delay-line entry: raw timing plus, with the backdrop, the checker bits.
  typedef struct packed {
`ifdef SCANOUT_BACKDROP_EN
    logic h4;
    logic v4;
`endif
    logic act;
    logic hs_n;
    logic vs_n;
  } tap_t;

  logic h_last;
  logic v_last;
  tap_t raw_c;
  tap_t idle_c;
  tap_t tap_c;
  tap_t pipe [PIPE_DELAY];
  logic [CWIDTH-1:0] colour_c;
  logic unused_pixel;

  assign h_last = (hdata == HWIDTH'(HTOTAL - 1));
  assign v_last = (vdata == VWIDTH'(VTOTAL - 1));

  // Beam counters and wrap strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdata       <= '0;
      vdata       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= en && h_last;
      frame_start <= en && h_last && v_last;
      if (en) begin
        if (h_last) begin
          hdata <= '0;
          vdata <= v_last ? '0 : vdata + VWIDTH'(1);
        end else begin
          hdata <= hdata + HWIDTH'(1);
        end
      end
    end
  end

  // Raw timing decoded straight from the counters.
  always_comb begin
    raw_c      = '0;
    raw_c.act  = (hdata < HWIDTH'(HSIZE)) && (vdata < VWIDTH'(VSIZE));
    raw_c.hs_n = !((hdata >= HWIDTH'(HS_BEG)) && (hdata < HWIDTH'(HS_END)));
    raw_c.vs_n = !((vdata >= VWIDTH'(VS_BEG)) && (vdata < VWIDTH'(VS_END)));
`ifdef SCANOUT_BACKDROP_EN
    raw_c.h4   = hdata[4];
    raw_c.v4   = vdata[4];
`endif
  end

  // Inactive entry loaded on reset: syncs deasserted, outside active area.
  always_comb begin
    idle_c      = '0;
    idle_c.hs_n = 1'b1;
    idle_c.vs_n = 1'b1;
  end

  // Entry that moves into the final stage on the next en-edge; the pixel
  // sampled on that same edge belongs to it.
  if (PIPE_DELAY == 1) begin : g_tap_raw
    assign tap_c = raw_c;
  end else begin : g_tap_pipe
    assign tap_c = pipe[PIPE_DELAY-2];
  end

  // Colour select for the entry entering the final stage.
  always_comb begin
    colour_c = pixel[CWIDTH-1:0];
`ifdef SCANOUT_BACKDROP_EN
    if (!pixel[DATA_WIDTH-1]) begin
      colour_c = (tap_c.h4 ^ tap_c.v4) ? CWIDTH'(12'h888) : CWIDTH'(12'h444);
    end
`endif
    if (!tap_c.act) begin
      colour_c = '0;
    end
  end

  // Timing delay line and registered colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_DELAY); i++) begin
        pipe[i] <= idle_c;
      end
      rgb <= '0;
    end else if (en) begin
      pipe[0] <= raw_c;
      for (int i = 1; i < int'(PIPE_DELAY); i++) begin
        pipe[i] <= pipe[i-1];
      end
      rgb <= colour_c;
    end
  end

  assign hsync = pipe[PIPE_DELAY-1].hs_n;
  assign vsync = pipe[PIPE_DELAY-1].vs_n;
  assign de    = pipe[PIPE_DELAY-1].act;

  // Flag and padding bits are only consumed by the optional backdrop.
  assign unused_pixel = ^pixel[DATA_WIDTH-1:CWIDTH];

endmodule
